case_1_sdiv_13s_4s_13_seq_1: RTL and testbench

- Multi-cycle signed integer divider. It is the inverse operator of the design's signed 12s×4s→13 multiplier core.
- Takes a 13-bit signed dividend and a 4-bit signed divisor. Produces a 13-bit signed quotient and a 4-bit signed remainder, using C semantics (truncate toward zero).
- Radix-2 restoring iteration on operand magnitudes, followed by a sign-fix stage.
- Sits alongside the combinational arithmetic cores and is driven by the HLS datapath FSM through a start/done handshake with clock enable.

---
 rtl/case_1_sdiv_13s_4s_13_seq_1_if.sv | 25 ++
 rtl/case_1_sdiv_13s_4s_13_seq_1.sv | 108 ++++++++++
 tb/tb_case_1_sdiv_13s_4s_13_seq_1.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/case_1_sdiv_13s_4s_13_seq_1_if.sv
// Start/done handshake bundle for the sequential signed divider: operands in,
// busy/done status and the registered quotient/remainder out.
interface case_1_sdiv_13s_4s_13_seq_1_if #(
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 4,
  parameter int dout_WIDTH = 13
);
  logic                  start;
  logic [din0_WIDTH-1:0] dividend0;
  logic [din1_WIDTH-1:0] divisor0;
  logic                  busy;
  logic                  done;
  logic [dout_WIDTH-1:0] quot;
  logic [din1_WIDTH-1:0] remd;

  modport master (
    output start, dividend0, divisor0,
    input  busy, done, quot, remd
  );

  modport slave (
    input  start, dividend0, divisor0,
    output busy, done, quot, remd
  );
endinterface

// File: rtl/case_1_sdiv_13s_4s_13_seq_1.sv
// Multi-cycle signed divider (C truncation semantics): radix-2 restoring steps on
// operand magnitudes, then a sign-fix stage. One step per ce=1 clock.
module case_1_sdiv_13s_4s_13_seq_1 #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 15,
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 4,
  parameter int dout_WIDTH = 13
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic ce,
  case_1_sdiv_13s_4s_13_seq_1_if.slave bus
);

  localparam int CNT_W = $clog2(din0_WIDTH + 1);

  if (NUM_STAGE != din0_WIDTH + 2 || ID < 0) begin : g_param_check
    $error("NUM_STAGE must equal din0_WIDTH+2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t                state, state_next;
  logic [din0_WIDTH-1:0] dvd;      // dividend magnitude, consumed MSB first
  logic [din1_WIDTH-1:0] dvs;      // divisor magnitude
  logic [din1_WIDTH-1:0] rem;      // partial remainder, always < |divisor| for nonzero divisor
  logic [din0_WIDTH-1:0] q;
  logic [CNT_W-1:0]      count;
  logic                  sign_q, sign_r;

  logic [din0_WIDTH-1:0] dvd_in_mag;
  logic [din1_WIDTH-1:0] dvs_in_mag;
  logic [din1_WIDTH:0]   rem_shift;
  logic                  sub_ok;
  logic [din1_WIDTH-1:0] rem_step;

  // Unsigned reading of the negated value covers the most negative input
  // (e.g. -4096 -> 4096), so no extra magnitude bit is stored.
  assign dvd_in_mag = bus.dividend0[din0_WIDTH-1] ? -bus.dividend0 : bus.dividend0;
  assign dvs_in_mag = bus.divisor0[din1_WIDTH-1]  ? -bus.divisor0  : bus.divisor0;

  assign rem_shift = {rem, dvd[din0_WIDTH-1]};
  assign sub_ok    = rem_shift >= {1'b0, dvs};
  assign rem_step  = sub_ok ? (rem_shift[din1_WIDTH-1:0] - dvs) : rem_shift[din1_WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge ap_clk) begin
    if (ap_rst)  state <= S_IDLE;
    else if (ce) state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_next = S_RUN;
      S_RUN:   if (count == CNT_W'(1)) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: the iteration registers are deliberately not reset: every one is
  // reloaded on accept and nothing reads them outside RUN/FIX.
  always_ff @(posedge ap_clk) begin
    if (ce) begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            dvd    <= dvd_in_mag;
            dvs    <= dvs_in_mag;
            // A zero divisor yields all-ones quotient bits; keep them unsigned.
            sign_q <= (bus.dividend0[din0_WIDTH-1] ^ bus.divisor0[din1_WIDTH-1]) & (|bus.divisor0);
            sign_r <= bus.dividend0[din0_WIDTH-1];
            rem    <= '0;
            q      <= '0;
            count  <= CNT_W'(din0_WIDTH);
          end
        end
        S_RUN: begin
          dvd   <= {dvd[din0_WIDTH-2:0], 1'b0};
          rem   <= rem_step;
          q     <= {q[din0_WIDTH-2:0], sub_ok};
          count <= count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      bus.quot <= '0;
      bus.remd <= '0;
    end else if (ce && state == S_FIX) begin
      bus.quot <= dout_WIDTH'(sign_q ? -q : q);
      bus.remd <= sign_r ? -rem : rem;
    end
  end

  assign bus.busy = (state == S_RUN) || (state == S_FIX);
  assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_case_1_sdiv_13s_4s_13_seq_1.sv
// Directed bench for the sequential signed divider: stimulus pushes expected
// results; a negedge monitor pops and compares them on each done pulse.
module tb_case_1_sdiv_13s_4s_13_seq_1;

  localparam int W0 = 13;
  localparam int W1 = 4;
  localparam int WQ = 13;

  typedef struct {
    logic [WQ-1:0] q;
    logic [W1-1:0] r;
    int            at;
  } exp_t;

  logic ap_clk = 1'b0;
  logic ap_rst;
  logic ce;
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   last_t    = 0;
  bit   done_seen = 1'b0;
  exp_t sb[$];

  case_1_sdiv_13s_4s_13_seq_1_if #(.din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WQ)) sif ();

  case_1_sdiv_13s_4s_13_seq_1 #(
    .ID(1), .NUM_STAGE(15), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WQ)
  ) u_dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .ce     (ce),
    .bus    (sif)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic push_exp(input logic [WQ-1:0] q, input logic [W1-1:0] r, input int at);
    exp_t e;
    e.q = q;
    e.r = r;
    e.at = at;
    sb.push_back(e);
  endtask

  // Accepting edge becomes last_t; done is expected in the cycle after edge last_t+14.
  task automatic issue(input logic [W0-1:0] a, input logic [W1-1:0] b,
                       input logic [WQ-1:0] q, input logic [W1-1:0] r,
                       input int stall, input bit expect_done);
    sif.dividend0 = a;
    sif.divisor0  = b;
    sif.start     = 1'b1;
    tick();
    sif.start = 1'b0;
    last_t    = cyc;
    if (expect_done) push_exp(q, r, last_t + 14 + stall);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_vec(input logic [W0-1:0] a, input logic [W1-1:0] b,
                         input logic [WQ-1:0] q, input logic [W1-1:0] r);
    issue(a, b, q, r, 0, 1'b1);
    drain();
  endtask

  always @(negedge ap_clk) begin
    if (sif.done && !done_seen) begin
      done_seen = 1'b1;
      if (sb.size() == 0) begin
        check("spurious_done", sif.done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quot", sif.quot, e.q);
        check("remd", sif.remd, e.r);
        check("latency", cyc, e.at);
      end
    end else if (!sif.done) begin
      done_seen = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sif.start     = 1'b0;
    sif.dividend0 = '0;
    sif.divisor0  = '0;
    ap_rst        = 1'b1;
    ce            = 1'b0;
    repeat (3) tick();
    check("rst_busy", sif.busy, 0);
    check("rst_done", sif.done, 0);
    check("rst_quot", sif.quot, 0);
    check("rst_remd", sif.remd, 0);
    ap_rst = 1'b0;
    ce     = 1'b1;
    tick();

    // Basic latency and busy window; operands changed mid-run must not matter.
    issue(13'd100, 4'd7, 13'h000E, 4'd2, 0, 1'b1);
    check("busy_accept", sif.busy, 1);
    for (int k = 1; k <= 13; k++) begin
      if (k == 3) begin
        sif.dividend0 = 13'h1ABC;
        sif.divisor0  = 4'h3;
      end
      tick();
      check("busy_run", sif.busy, 1);
    end
    tick();
    check("busy_done", sif.busy, 0);
    check("done_pulse", sif.done, 1);
    drain();

    // Sign combinations, overflow wrap, divide by zero, range corners.
    run_vec(13'h1F9C, 4'd7,  13'h1FF2, 4'hE);
    run_vec(13'd100,  4'h8,  13'h1FF4, 4'd4);
    run_vec(13'h1000, 4'hF,  13'h1000, 4'd0);
    run_vec(13'd5,    4'd0,  13'h1FFF, 4'd5);
    run_vec(13'h1FF9, 4'd2,  13'h1FFD, 4'hF);
    run_vec(13'h0FFF, 4'h9,  13'h1DB7, 4'd0);
    run_vec(13'h1000, 4'd7,  13'h1DB7, 4'hF);
    run_vec(13'h1000, 4'h8,  13'h0200, 4'd0);
    run_vec(13'd3,    4'hB,  13'h0000, 4'd3);

    // start during RUN and during DONE is dropped.
    issue(13'd100, 4'd7, 13'h000E, 4'd2, 0, 1'b1);
    while (cyc < last_t + 2) tick();
    sif.dividend0 = 13'd50;
    sif.divisor0  = 4'd3;
    sif.start     = 1'b1;
    tick();
    sif.start = 1'b0;
    while (cyc < last_t + 14) tick();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    tick();
    check("ignored_busy", sif.busy, 0);
    repeat (20) tick();
    check("ignored_sb", sb.size(), 0);

    // start held high: accepts 16 cycles apart, results in order.
    sif.dividend0 = 13'd50;
    sif.divisor0  = 4'd3;
    sif.start     = 1'b1;
    tick();
    last_t = cyc;
    push_exp(13'h0010, 4'd2, last_t + 14);
    sif.dividend0 = 13'h1FCE;
    repeat (16) tick();
    sif.start = 1'b0;
    push_exp(13'h1FF0, 4'hE, last_t + 30);
    drain();

    // ce low for 5 cycles mid-RUN stretches latency by exactly 5.
    issue(13'h03E8, 4'hD, 13'h1EB3, 4'd1, 5, 1'b1);
    repeat (4) tick();
    ce = 1'b0;
    repeat (5) tick();
    check("stall_busy", sif.busy, 1);
    ce = 1'b1;
    drain();

    // ce low during the done cycle holds done until ce returns.
    issue(13'd77, 4'd5, 13'h000F, 4'd2, 0, 1'b1);
    while (cyc < last_t + 14) tick();
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("done_hold", sif.done, 1);
    end
    ce = 1'b1;
    tick();
    check("done_clear", sif.done, 0);
    check("hold_sb", sb.size(), 0);

    // Reset mid-RUN aborts without a done; a fresh start then completes.
    issue(13'd200, 4'd3, 13'h0000, 4'd0, 0, 1'b0);
    repeat (6) tick();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    check("abort_busy", sif.busy, 0);
    check("abort_done", sif.done, 0);
    check("abort_quot", sif.quot, 0);
    check("abort_remd", sif.remd, 0);
    repeat (20) tick();
    run_vec(13'd123, 4'hC, 13'h1FE2, 4'd3);

    repeat (3) tick();
    check("final_sb", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
